bram_port_arbiter: RTL and testbench

- Shares one single-port block RAM (32-bit, 512 words, 1- or 2-cycle read latency) between two requesters: requester 0, the array-sum engine's read port, and requester 1, a loader or host port that reads and writes.
- Performs round-robin arbitration with an optional bounded lock for bursts.
- Drives the BRAM port directly and routes read data back with per-requester valid strobes.
- Sits between the requesters and the BRAM macro in the sum-of-array datapath.

---
 rtl/bram_port_arbiter.sv | 124 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port BRAM, with bounded
// burst locking and per-requester read-return strobes.
module bram_port_arbiter #(
   parameter int AW        = 9,
   parameter int DW        = 32,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            r0_req,
   input  logic            r0_we,
   input  logic            r0_lock,
   input  logic [AW-1:0]   r0_addr,
   input  logic [DW-1:0]   r0_wdata,
   output logic            r0_gnt,
   output logic            r0_rvalid,
   input  logic            r1_req,
   input  logic            r1_we,
   input  logic            r1_lock,
   input  logic [AW-1:0]   r1_addr,
   input  logic [DW-1:0]   r1_wdata,
   output logic            r1_gnt,
   output logic            r1_rvalid,
   output logic [DW-1:0]   rdata,
   output logic            bram_en,
   output logic [DW/8-1:0] bram_we,
   output logic [AW-1:0]   bram_addr,
   output logic [DW-1:0]   bram_di,
   input  logic [DW-1:0]   bram_do
);

   localparam logic [7:0] MAX_B = 8'(MAX_BURST);

   logic              ptr;
   logic              lk_vld;
   logic              lk_id;
   logic [7:0]        burst_cnt;
   logic              gnt_any;
   logic              gnt_id;
   logic              sel_we;
   logic              sel_lock;
   logic              other_req;
   logic [AW-1:0]     sel_addr;
   logic [DW-1:0]     sel_wdata;
   logic [AW-1:0]     addr_hold;
   logic [DW-1:0]     di_hold;
   logic [RD_LAT-1:0] vld_p;
   logic [RD_LAT-1:0] rid_p;

   // Arbitration: the owner's lock is ignored once it has used up its burst
   always_comb begin
      gnt_any = r0_req | r1_req;
      gnt_id  = r1_req;
      if (r0_req && r1_req) begin
         if (lk_vld)
            gnt_id = (burst_cnt >= MAX_B) ? ~lk_id : lk_id;
         else
            gnt_id = ptr;
      end
   end

   always_comb begin
      sel_we    = gnt_id ? r1_we    : r0_we;
      sel_lock  = gnt_id ? r1_lock  : r0_lock;
      sel_addr  = gnt_id ? r1_addr  : r0_addr;
      sel_wdata = gnt_id ? r1_wdata : r0_wdata;
      other_req = gnt_id ? r0_req   : r1_req;
   end

   assign r0_gnt    = gnt_any & ~gnt_id;
   assign r1_gnt    = gnt_any &  gnt_id;
   assign bram_en   = gnt_any;
   assign bram_we   = {(DW/8){gnt_any & sel_we}};
   assign bram_addr = gnt_any ? sel_addr  : addr_hold;
   assign bram_di   = gnt_any ? sel_wdata : di_hold;

   // Stage p0 -> p1: arbitration state and read-return pipeline
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr       <= 1'b0;
         lk_vld    <= 1'b0;
         lk_id     <= 1'b0;
         burst_cnt <= 8'd0;
         vld_p     <= '0;
         rid_p     <= '0;
      end else begin
         if (gnt_any) begin
            ptr <= ~gnt_id;
            if (sel_lock) begin
               lk_vld    <= 1'b1;
               lk_id     <= gnt_id;
               burst_cnt <= ((lk_vld && (lk_id == gnt_id)) ? burst_cnt : 8'd0)
                            + {7'd0, other_req};
            end else begin
               lk_vld    <= 1'b0;
               burst_cnt <= 8'd0;
            end
         end else begin
            lk_vld    <= 1'b0;
            burst_cnt <= 8'd0;
         end
         vld_p[0] <= gnt_any & ~sel_we;
         rid_p[0] <= gnt_id;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_p[i] <= vld_p[i-1];
            rid_p[i] <= rid_p[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (gnt_any) begin
         addr_hold <= sel_addr;
         di_hold   <= sel_wdata;
      end
   end

   // Stage p(RD_LAT): BRAM output lines up with the tail of the pipeline
   assign r0_rvalid = vld_p[RD_LAT-1] & ~rid_p[RD_LAT-1];
   assign r1_rvalid = vld_p[RD_LAT-1] &  rid_p[RD_LAT-1];
   assign rdata     = bram_do;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: one RD_LAT=1 instance and one RD_LAT=2
// instance share the requester stimulus, each with its own BRAM model.
module tb_bram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset, rst2;
   logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
   logic [8:0]  r0_addr, r1_addr;
   logic [31:0] r0_wdata, r1_wdata;

   logic        g0, g1, rv0, rv1, en1;
   logic [31:0] rd1, di1, do1;
   logic [3:0]  we1;
   logic [8:0]  addr1;
   logic        g0b, g1b, rv0b, rv1b, en2;
   logic [31:0] rd2, di2, do2a, do2b;
   logic [3:0]  we2;
   logic [8:0]  addr2;

   logic [31:0] mem1 [512];
   logic [31:0] mem2 [512];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bram_port_arbiter #(.AW(9), .DW(32), .RD_LAT(1), .MAX_BURST(4)) u1 (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_gnt(g0), .r0_rvalid(rv0),
      .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_gnt(g1), .r1_rvalid(rv1),
      .rdata(rd1), .bram_en(en1), .bram_we(we1), .bram_addr(addr1),
      .bram_di(di1), .bram_do(do1));

   bram_port_arbiter #(.AW(9), .DW(32), .RD_LAT(2), .MAX_BURST(4)) u2 (
      .clk(clk), .reset(rst2),
      .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_gnt(g0b), .r0_rvalid(rv0b),
      .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_gnt(g1b), .r1_rvalid(rv1b),
      .rdata(rd2), .bram_en(en2), .bram_we(we2), .bram_addr(addr2),
      .bram_di(di2), .bram_do(do2b));

   // WRITE_FIRST BRAM models, preloaded with mem[k] = k+1 while reset is low
   always @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 512; k++) begin
            mem1[k] <= 32'(k + 1);
            mem2[k] <= 32'(k + 1);
         end
      end else begin
         if (en1) begin
            if (we1[0]) begin
               mem1[addr1] <= di1;
               do1         <= di1;
            end else begin
               do1 <= mem1[addr1];
            end
         end
         if (en2) begin
            if (we2[0]) begin
               mem2[addr2] <= di2;
               do2a        <= di2;
            end else begin
               do2a <= mem2[addr2];
            end
         end
         do2b <= do2a;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; rst2 = 1'b0;
      r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
      r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_en", 32'(en1), 32'd0);
      chk("rst_we", 32'(we1), 32'd0);
      reset = 1'b1; rst2 = 1'b1;
      next_cycle();

      // Idle after reset
      @(negedge clk);
      chk("idle_gnt", 32'({g0, g1}), 32'd0);
      chk("idle_rvalid", 32'({rv0, rv1}), 32'd0);
      chk("idle_en", 32'(en1), 32'd0);
      chk("idle_we", 32'(we1), 32'd0);
      next_cycle();

      // Single reader, back-to-back addresses 0..4
      for (int k = 0; k < 5; k++) begin
         r0_req = 1; r0_addr = 9'(k);
         @(negedge clk);
         chk("sr_gnt0", 32'(g0), 32'd1);
         chk("sr_gnt1", 32'(g1), 32'd0);
         chk("sr_addr", 32'(addr1), 32'(k));
         chk("sr_rv0", 32'(rv0), 32'(k > 0));
         chk("sr_rv1", 32'(rv1), 32'd0);
         if (k > 0) chk("sr_rdata", rd1, 32'(k));
         next_cycle();
      end
      r0_req = 0;
      @(negedge clk);
      chk("sr_last_rv0", 32'(rv0), 32'd1);
      chk("sr_last_rdata", rd1, 32'd5);
      chk("sr_idle_en", 32'(en1), 32'd0);
      next_cycle();

      // Lone r1 read of addr 7; leaves the pointer on requester 0
      r1_req = 1; r1_addr = 9'd7;
      @(negedge clk);
      chk("r1_gnt", 32'(g1), 32'd1);
      next_cycle();
      r1_req = 0;
      @(negedge clk);
      chk("r1_rv1", 32'(rv1), 32'd1);
      chk("r1_rdata", rd1, 32'd8);
      next_cycle();

      // Contention without lock alternates r0, r1, r0, r1
      r0_req = 1; r0_addr = 9'd2; r1_req = 1; r1_addr = 9'd7;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rr_gnt0", 32'(g0), 32'(i % 2 == 0));
         chk("rr_gnt1", 32'(g1), 32'(i % 2 == 1));
         chk("rr_rv0", 32'(rv0), 32'(i > 0 && (i - 1) % 2 == 0));
         chk("rr_rv1", 32'(rv1), 32'(i > 0 && (i - 1) % 2 == 1));
         if (i > 0) chk("rr_rdata", rd1, ((i - 1) % 2 == 0) ? 32'd3 : 32'd8);
         next_cycle();
      end
      r0_req = 0; r1_req = 0;
      @(negedge clk);
      chk("rr_last_rv1", 32'(rv1), 32'd1);
      chk("rr_last_rdata", rd1, 32'd8);
      next_cycle();

      // r1 writes, then r0 reads the same word back
      r1_req = 1; r1_we = 1; r1_addr = 9'd9; r1_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("wr_gnt1", 32'(g1), 32'd1);
      chk("wr_we", 32'(we1), 32'hF);
      chk("wr_addr", 32'(addr1), 32'd9);
      chk("wr_di", di1, 32'hDEADBEEF);
      next_cycle();
      r1_req = 0; r1_we = 0; r0_req = 1; r0_addr = 9'd9;
      @(negedge clk);
      chk("rd_gnt0", 32'(g0), 32'd1);
      chk("rd_we", 32'(we1), 32'd0);
      chk("wr_no_rv1", 32'(rv1), 32'd0);
      next_cycle();
      r0_req = 0;
      @(negedge clk);
      chk("rd_rv0", 32'(rv0), 32'd1);
      chk("rd_rdata", rd1, 32'hDEADBEEF);
      chk("rd_no_rv1", 32'(rv1), 32'd0);
      next_cycle();

      // Bounded lock: r1 locks, r0 waits; r0 breaks in after four r1 grants
      r0_req = 1; r0_addr = 9'd0; r1_req = 1; r1_lock = 1; r1_addr = 9'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("lk_gnt1", 32'(g1), 32'(i % 5 != 4));
         chk("lk_gnt0", 32'(g0), 32'(i % 5 == 4));
         next_cycle();
      end
      r0_req = 0; r1_req = 0; r1_lock = 0;
      next_cycle();

      // Two-cycle read latency on the RD_LAT=2 instance
      r0_req = 1; r0_addr = 9'd3;
      @(negedge clk);
      chk("l2_gnt0", 32'(g0b), 32'd1);
      next_cycle();
      r0_req = 0;
      @(negedge clk);
      chk("l2_rv0_early", 32'(rv0b), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("l2_rv0", 32'(rv0b), 32'd1);
      chk("l2_rdata", rd2, 32'd4);
      next_cycle();

      // Reset the cycle after a read grant: the read never returns
      r0_req = 1; r0_addr = 9'd4;
      @(negedge clk);
      chk("mr_gnt0", 32'(g0b), 32'd1);
      next_cycle();
      r0_req = 0; rst2 = 1'b0;
      @(negedge clk);
      chk("mr_rv0_a", 32'(rv0b), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("mr_rv0_b", 32'(rv0b), 32'd0);
      next_cycle();
      rst2 = 1'b1;
      @(negedge clk);
      chk("mr_rv0_c", 32'(rv0b), 32'd0);
      next_cycle();
      r0_req = 1; r0_addr = 9'd5; r1_req = 1; r1_addr = 9'd6;
      @(negedge clk);
      chk("mr_ptr_gnt0", 32'(g0b), 32'd1);
      chk("mr_ptr_gnt1", 32'(g1b), 32'd0);
      next_cycle();
      r0_req = 0; r1_req = 0;
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
